// File: rtl/ifq_arb_pkg.sv
// Shared helpers for the IFQ round-robin arbiters: index width and wrapped pointer increment.
// Used by rr_arbiter and rr_arb_mux (optional lock feature: RR_ARB_MUX_LOCK_EN).
package ifq_arb_pkg;

    function automatic int sel_width(input int n);
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    // Explicit wrap keeps non-power-of-2 channel counts in range.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr == n - 32'sd1) ? 32'sd0 : ptr + 32'sd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index scanning cyclically from i_ptr.
// Reusable for any IFQ port; parametrised by channel count only.
module rr_arbiter
    import ifq_arb_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = sel_width(N)
) (
    input  logic [N-1:0]    i_valid,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_grant,
    output logic            o_gnt_any
);

    localparam logic [SELW:0] L_N = (SELW + 1)'(N);

    logic [2*N-1:0] w_dbl;
    logic [SELW-1:0] w_off;
    logic [SELW:0]   w_sum;

    // Rotate valids so the pointer sits at bit 0, take the lowest set offset, rotate back.
    always_comb begin
        w_dbl = {i_valid, i_valid} >> i_ptr;
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_off = w_dbl[k] ? SELW'(k) : w_off;
        end
        w_sum     = {1'b0, i_ptr} + {1'b0, w_off};
        o_grant   = (w_sum >= L_N) ? SELW'(w_sum - L_N) : w_sum[SELW-1:0];
        o_gnt_any = |i_valid;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready mux with round-robin arbitration and a one-entry output register.
// Define RR_ARB_MUX_LOCK_EN to add X_LAST and hold the grant on a channel until its last beat.
module rr_arb_mux
    import ifq_arb_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X [N-1:0],
    input  logic [N-1:0]     X_VALID,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N-1:0]     X_LAST,
`endif
    output logic [N-1:0]     X_READY,
    output logic [WIDTH-1:0] Y,
    output logic             Y_VALID,
    input  logic             Y_READY,
    output logic [SELW-1:0]  Y_SEL
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SELW-1:0]  r_y_sel;

    logic [SELW-1:0]  w_arb_grant;
    logic             w_arb_any;
    logic [SELW-1:0]  w_grant;
    logic             w_gnt_any;
    logic             w_last;
    logic             w_accept;
    logic [SELW-1:0]  w_ptr_next;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             r_lock;
    logic [SELW-1:0]  r_lock_ch;
`endif

    rr_arbiter #(.N(N)) u_arb (
        .i_valid   (X_VALID),
        .i_ptr     (r_ptr),
        .o_grant   (w_arb_grant),
        .o_gnt_any (w_arb_any)
    );

    // Final grant: a locked channel overrides the round-robin pick.
    always_comb begin
`ifdef RR_ARB_MUX_LOCK_EN
        w_grant   = r_lock ? r_lock_ch : w_arb_grant;
        w_gnt_any = r_lock ? X_VALID[r_lock_ch] : w_arb_any;
        w_last    = X_LAST[w_grant];
`else
        w_grant   = w_arb_grant;
        w_gnt_any = w_arb_any;
        w_last    = 1'b1;
`endif
        w_accept   = !r_y_valid || Y_READY;
        w_ptr_next = SELW'(rr_next(int'(w_grant), N));
    end

    // Ready is one-hot on the grant when the slot can take a word, and held low in reset.
    always_comb begin
        X_READY = '0;
        if (rst_n && w_accept && w_gnt_any) begin
            X_READY[w_grant] = 1'b1;
        end else begin
            X_READY = '0;
        end
    end

    // Output register and priority pointer; drain and refill may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_sel   <= '0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            if (w_gnt_any) begin
                r_y       <= X[w_grant];
                r_y_sel   <= w_grant;
                r_y_valid <= 1'b1;
                if (w_last) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // Lock tracks the channel of a multi-beat transfer until its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_accept && w_gnt_any) begin
            r_lock    <= !w_last;
            r_lock_ch <= w_grant;
        end
    end
`endif

    assign Y       = r_y;
    assign Y_VALID = r_y_valid;
    assign Y_SEL   = r_y_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: a 4-channel and a 3-channel instance against a queue-free
// cyclic-scan reference model, directed vector table, corner sequences and random traffic.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] x4 [3:0];
    logic [3:0] xv4, xl4, xr4;
    logic       yr4, yv4;
    logic [7:0] y4;
    logic [1:0] ys4;

    logic [7:0] x3 [2:0];
    logic [2:0] xv3, xl3, xr3;
    logic       yr3, yv3;
    logic [7:0] y3;
    logic [1:0] ys3;

    rr_arb_mux #(.WIDTH(8), .N(4)) d4 (
        .clk(clk), .rst_n(rst_n), .X(x4), .X_VALID(xv4),
`ifdef RR_ARB_MUX_LOCK_EN
        .X_LAST(xl4),
`endif
        .X_READY(xr4), .Y(y4), .Y_VALID(yv4), .Y_READY(yr4), .Y_SEL(ys4)
    );

    rr_arb_mux #(.WIDTH(8), .N(3)) d3 (
        .clk(clk), .rst_n(rst_n), .X(x3), .X_VALID(xv3),
`ifdef RR_ARB_MUX_LOCK_EN
        .X_LAST(xl3),
`endif
        .X_READY(xr3), .Y(y3), .Y_VALID(yv3), .Y_READY(yr3), .Y_SEL(ys3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance (0: N=4, 1: N=3)
    int         m_ptr  [2];
    int         m_sel  [2];
    int         m_lock [2];
    int         m_lch  [2];
    logic       m_yv   [2];
    logic [7:0] m_y    [2];

    typedef struct {
        logic [3:0] xv;
        logic       yr;
        logic [1:0] sel;
        logic [7:0] y;
        logic       yv;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_sel[d] = 0; m_lock[d] = 0; m_lch[d] = 0;
            m_yv[d] = 1'b0; m_y[d] = 8'h00;
        end
    endtask

    function automatic int mgrant(input int d, input int n, input logic [3:0] v);
        int i;
        if (m_lock[d] != 0) return v[m_lch[d]] ? m_lch[d] : -1;
        for (int k = 0; k < n; k++) begin
            i = (m_ptr[d] + k) % n;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] erdy(input int d, input int n, input logic [3:0] v, input logic yr);
        int g;
        g = mgrant(d, n, v);
        if ((!m_yv[d] || yr) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic mupd(input int d, input int n, input logic [3:0] v, input logic [3:0] xl,
                        input logic yr, input logic [31:0] xp);
        int g;
        g = mgrant(d, n, v);
        if (!m_yv[d] || yr) begin
            if (g >= 0) begin
                m_y[d]   = xp[8*g +: 8];
                m_sel[d] = g;
                m_yv[d]  = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
                if (!xl[g]) begin
                    m_lock[d] = 1; m_lch[d] = g;
                end else begin
                    m_lock[d] = 0; m_ptr[d] = (g + 1) % n;
                end
`else
                m_ptr[d] = (g + 1) % n;
`endif
            end else begin
                m_yv[d] = 1'b0;
            end
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge, check outputs after.
    task automatic tick();
        logic [3:0] e4, e3;
        #1;
        e4 = erdy(0, 4, xv4, yr4);
        e3 = erdy(1, 3, {1'b0, xv3}, yr3);
        chk("x_ready4", 32'(xr4), 32'(e4));
        chk("x_ready3", 32'(xr3), 32'(e3));
        @(posedge clk);
        mupd(0, 4, xv4, xl4, yr4, {x4[3], x4[2], x4[1], x4[0]});
        mupd(1, 3, {1'b0, xv3}, {1'b1, xl3}, yr3, {8'h00, x3[2], x3[1], x3[0]});
        #1;
        chk("y4", 32'(y4), 32'(m_y[0]));
        chk("y_valid4", 32'(yv4), 32'(m_yv[0]));
        chk("y_sel4", 32'(ys4), 32'(m_sel[0]));
        chk("y3", 32'(y3), 32'(m_y[1]));
        chk("y_valid3", 32'(yv3), 32'(m_yv[1]));
        chk("y_sel3", 32'(ys3), 32'(m_sel[1]));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{4'hF, 1'b1, 2'(i % 4), 8'(16 + i % 4), 1'b1};
        tbl[8]  = '{4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
        tbl[9]  = '{4'b0000, 1'b1, 2'd1, 8'h11, 1'b0};
        tbl[10] = '{4'b1111, 1'b1, 2'd2, 8'h12, 1'b1};

        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) x4[c] = 8'(8'h10 + c);
        for (int c = 0; c < 3; c++) x3[c] = 8'(8'h30 + c);
        xv4 = 4'hF; yr4 = 1'b1; xl4 = 4'hF;
        xv3 = 3'b000; yr3 = 1'b1; xl3 = 3'b111;
        mreset();
        #2;
        chk("rst_x_ready", 32'(xr4), 32'h0);
        chk("rst_y", 32'(y4), 32'h0);
        chk("rst_y_valid", 32'(yv4), 32'h0);
        chk("rst_y_sel", 32'(ys4), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset honoured mid-transfer: load 0xAA under back-pressure, then reset off-edge
        x4[0] = 8'hAA; xv4 = 4'b0001; yr4 = 1'b0;
        tick();
        chk("load_aa", 32'(y4), 32'hAA);
        x4[0] = 8'h10; xv4 = 4'hF; yr4 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_y_valid", 32'(yv4), 32'h0);
        chk("midrst_y", 32'(y4), 32'h0);
        chk("midrst_y_sel", 32'(ys4), 32'h0);
        chk("midrst_x_ready", 32'(xr4), 32'h0);
        mreset();
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin without bubbles, then single word and drain
        for (int i = 0; i < 11; i++) begin
            xv4 = tbl[i].xv; yr4 = tbl[i].yr;
            tick();
            chk("tbl_sel", 32'(ys4), 32'(tbl[i].sel));
            chk("tbl_y", 32'(y4), 32'(tbl[i].y));
            chk("tbl_valid", 32'(yv4), 32'(tbl[i].yv));
        end

        // Back-pressure with Y=0x12 held, then same-cycle reload
        xv4 = 4'hF; yr4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_y", 32'(y4), 32'h12);
            chk("stall_sel", 32'(ys4), 32'h2);
            chk("stall_valid", 32'(yv4), 32'h1);
            chk("stall_x_ready", 32'(xr4), 32'h0);
        end
        yr4 = 1'b1;
        tick();
        chk("reload_y", 32'(y4), 32'h13);
        chk("reload_sel", 32'(ys4), 32'h3);
        chk("reload_valid", 32'(yv4), 32'h1);

        // N=3 wrap: pointer to 2 via channel 1, then channels 2 and 0 alternate
        xv4 = 4'b0000;
        xv3 = 3'b010;
        tick();
        chk("n3_first", 32'(ys3), 32'h1);
        xv3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_wrap_sel", 32'(ys3), (i % 2 == 0) ? 32'h2 : 32'h0);
        end
        xv3 = 3'b000;

`ifdef RR_ARB_MUX_LOCK_EN
        // Lock: channel 1 sends three beats while 0 and 2 stay valid
        xv4 = 4'b0001;
        tick();
        xv4 = 4'b0111; xl4 = 4'b1101;
        tick();
        chk("lock_sel1", 32'(ys4), 32'h1);
        chk("lock_rdy1", 32'(xr4), 32'h2);
        tick();
        chk("lock_sel2", 32'(ys4), 32'h1);
        chk("lock_rdy2", 32'(xr4), 32'h2);
        xl4 = 4'hF;
        tick();
        chk("lock_sel3", 32'(ys4), 32'h1);
        tick();
        chk("lock_after", 32'(ys4), 32'h2);
`endif

        // Random traffic against the model, with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            xv4 = 4'($urandom); yr4 = ($urandom % 4) != 0;
            xv3 = 3'($urandom); yr3 = ($urandom % 4) != 0;
            xl4 = 4'($urandom); xl3 = 3'($urandom);
            for (int c = 0; c < 4; c++) x4[c] = 8'($urandom);
            for (int c = 0; c < 3; c++) x3[c] = 8'($urandom);
            tick();
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_valid4", 32'(yv4), 32'h0);
                chk("rnd_rst_valid3", 32'(yv3), 32'h0);
                chk("rnd_rst_ready4", 32'(xr4), 32'h0);
                mreset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- N-channel, WIDTH-bit multiplexer with valid/ready handshake on every input and on the single output.
- A round-robin arbiter picks the channel; a one-entry output register holds the result.
- Successor to the purely combinational parametrised mux. Used in the IFQ to merge fetch/refill streams onto one queue write port with fair, back-pressure-aware selection.

Parameters:
WIDTH, 32, bits per data channel
N, 4, number of input channels (N >= 2, need not be a power of 2)
SELW, $clog2(N), width of the selected-channel index (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
X  in  [WIDTH-1:0] x [N-1:0]  input data per channel
X_VALID  in  N  per-channel valid
X_READY  out  N  per-channel ready (combinational)
Y  out  WIDTH  registered output data
Y_VALID  out  1  registered output valid
Y_READY  in  1  downstream ready
Y_SEL  out  SELW  index of the channel that produced Y (registered)

Behaviour:
- Reset is asynchronous on rst_n low and is honoured mid-transfer. A held entry is dropped and the pointer returns to 0.
- Reset values:
  - Y = 0, Y_VALID = 0, Y_SEL = 0, priority pointer PTR = 0.
  - X_READY = 0 while rst_n is low.
- Slot availability: accept = !Y_VALID || Y_READY.
- Grant selection:
  - grant = first index i, scanning cyclically PTR, PTR+1, ..., N-1, 0, ..., PTR-1, with X_VALID[i] = 1.
  - gnt_any = |X_VALID.
- Ready generation:
  - X_READY[i] = accept && gnt_any && (grant == i). This is one-hot or zero.
  - X_READY does not depend on X_VALID[i] of other channels beyond the arbitration result.
  - A channel may not rely on X_READY before asserting X_VALID.
- Transfer on channel i: X_VALID[i] && X_READY[i] at a rising edge. At that edge:
  - Y <= X[grant], Y_SEL <= grant, Y_VALID <= 1.
  - PTR <= (grant == N-1) ? 0 : grant+1. The wrap is explicit, so non-power-of-2 N is valid.
- Drain without refill (accept && !gnt_any): Y_VALID <= 0. Y and Y_SEL hold their last values. PTR holds.
- Stall (Y_VALID && !Y_READY):
  - Y, Y_SEL, Y_VALID and PTR are all stable.
  - All X_READY = 0.
- Simultaneous drain and fill (Y_VALID && Y_READY && gnt_any): the new word loads in the same cycle. Full throughput is one word per cycle with zero bubbles.
- Latency: one cycle from input transfer to Y_VALID.
- Fairness: a continuously valid channel is granted within N transfers.
- Input obligations:
  - Inputs must keep X[i] stable while X_VALID[i] && !X_READY[i].
  - The block does not check this.
- Width rule: PTR and grant are SELW bits. Index values >= N never occur.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- When defined:
  - Adds input X_LAST [N-1:0].
  - After channel i transfers with X_LAST[i] = 0, the arbiter locks to i. grant is forced to i, ignoring other valids, until a transfer with X_LAST[i] = 1.
  - PTR advances only on that last transfer.
  - Locked state resets to unlocked.
  - Other channels see X_READY = 0 while locked.
- When undefined: no X_LAST port. Every transfer is independently arbitrated and advances PTR, exactly as above.

Decomposition:
- Package ifq_arb_pkg holds:
  - function rr_next(ptr, n), returning the wrapped increment.
  - localparam-style helper for SELW.
- Sub-module rr_arbiter holds the combinational priority pick (X_VALID, PTR -> grant, gnt_any).
  - It is parametrised by N only.
  - It is reusable for other IFQ ports.
- rr_arb_mux instantiates it and owns PTR, the output register and the lock state.

Test Plan:
1. Reset mid-operation, N=4, WIDTH=8. Load Y=0xAA with Y_READY=0, then pull rst_n low off-edge -> immediately Y_VALID=0, Y=0, Y_SEL=0, X_READY=0. First grant after release comes from channel 0.
2. Round-robin, N=4, WIDTH=8. X_VALID=4'b1111 with X[i]=0x10+i and Y_READY=1 held for 8 cycles -> Y_SEL sequence 0,1,2,3,0,1,2,3, one per cycle, no bubbles.
3. Back-pressure. Y_VALID=1, Y=0x12, Y_READY=0 for 5 cycles -> Y, Y_SEL and PTR stable, X_READY=0. Y_READY=1 -> next word loads the same cycle.
4. Wrap with non-power-of-2, N=3. Only channels 2 and 0 valid, PTR=2 -> grants 2,0,2,0. PTR never reaches 3.
5. Drain. Single word from channel 1, then all X_VALID=0 with Y_READY=1 -> Y_VALID falls after one cycle, PTR=2, Y_SEL stays 1.
6. Lock (RR_ARB_MUX_LOCK_EN), N=4. Channel 1 sends 3 beats with X_LAST=0,0,1 while channels 0 and 2 are valid -> Y_SEL=1,1,1, then 2. Channels 0 and 2 see X_READY=0 during the lock.
